// File: rtl/pwm_duty_decoder_if.sv
// Signal bundle between a PWM source and the duty decoder.
// The master drives pwm_in; the slave (decoder) returns registered measurements.
interface pwm_duty_decoder_if;
    logic        pwm_in;
    logic [31:0] period_count;
    logic [31:0] high_count;
    logic [2:0]  duty_code;
    logic        steady;
    logic        valid;
    logic [1:0]  state_dbg;

    // valid is a one-cycle pulse with no back-pressure; the other outputs
    // change only in the cycle valid is high and hold their value otherwise.
    modport master (
        output pwm_in,
        input  period_count, high_count, duty_code, steady, valid, state_dbg
    );

    modport slave (
        input  pwm_in,
        output period_count, high_count, duty_code, steady, valid, state_dbg
    );
endinterface

// File: rtl/pwm_duty_decoder.sv
// Measures period and high time of an asynchronous PWM input, classifies the
// duty cycle into quarter steps, and reports a constant level after TIMEOUT cycles.
module pwm_duty_decoder #(
    parameter int unsigned TIMEOUT = 100000000
) (
    input  logic               clk,
    input  logic               rst,
    pwm_duty_decoder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    localparam logic [31:0] LIMIT = 32'(TIMEOUT);

    logic        sync1_q, sync2_q, s_d_q;
    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] hi_lat_q, hi_lat_d;
    logic [31:0] period_q, period_d;
    logic [31:0] high_q, high_d;
    logic [2:0]  duty_q, duty_d;
    logic        steady_q, steady_d;
    logic        valid_q, valid_d;

    logic        s, rise, fall, at_limit;
    logic [34:0] h8, p1, p3, p5, p7;
    logic [2:0]  duty_class;

    assign s        = sync2_q;
    assign rise     = s & ~s_d_q;
    assign fall     = ~s & s_d_q;
    assign at_limit = (cnt_q == LIMIT);

    // Compare 8H against odd multiples of P; 35 bits hold 8*(2^32-1).
    assign h8 = {hi_lat_q, 3'b000};
    assign p1 = {3'b000, cnt_q};
    assign p3 = p1 + (p1 << 1);
    assign p5 = p1 + (p1 << 2);
    assign p7 = (p1 << 3) - p1;

    always_comb begin
        duty_class = 3'd4;
        if (h8 < p1)      duty_class = 3'd0;
        else if (h8 < p3) duty_class = 3'd1;
        else if (h8 < p5) duty_class = 3'd2;
        else if (h8 < p7) duty_class = 3'd3;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_lat_d = hi_lat_q;
        period_d = period_q;
        high_d   = high_q;
        duty_d   = duty_q;
        steady_d = steady_q;
        valid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = HIGH;
                    cnt_d   = 32'd1;
                end
            end
            HIGH: begin
                if (fall) begin
                    hi_lat_d = cnt_q;
                    // Saturate so a fall landing on the limit still times out in LOW.
                    cnt_d    = at_limit ? cnt_q : cnt_q + 32'd1;
                    state_d  = LOW;
                end else if (at_limit) begin
                    period_d = '0;
                    high_d   = '0;
                    steady_d = 1'b1;
                    duty_d   = s ? 3'd4 : 3'd0;
                    valid_d  = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            LOW: begin
                if (rise) begin
                    period_d = cnt_q;
                    high_d   = hi_lat_q;
                    steady_d = 1'b0;
                    duty_d   = duty_class;
                    valid_d  = 1'b1;
                    cnt_d    = 32'd1;
                    state_d  = HIGH;
                end else if (at_limit) begin
                    period_d = '0;
                    high_d   = '0;
                    steady_d = 1'b1;
                    duty_d   = s ? 3'd4 : 3'd0;
                    valid_d  = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            s_d_q    <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_lat_q <= '0;
            period_q <= '0;
            high_q   <= '0;
            duty_q   <= '0;
            steady_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            sync1_q  <= bus.pwm_in;
            sync2_q  <= sync1_q;
            s_d_q    <= sync2_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_lat_q <= hi_lat_d;
            period_q <= period_d;
            high_q   <= high_d;
            duty_q   <= duty_d;
            steady_q <= steady_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.period_count = period_q;
    assign bus.high_count   = high_q;
    assign bus.duty_code    = duty_q;
    assign bus.steady       = steady_q;
    assign bus.valid        = valid_q;
    assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Self-checking bench for pwm_duty_decoder: timestamp-based reference model,
// per-cycle output comparison, and literal checks on directed scenarios.
module tb_pwm_duty_decoder;
  localparam int TIMEOUT = 64;
  localparam int W = 68;  // {steady, duty[2:0], high[31:0], period[31:0]}

  logic clk = 1'b0;
  logic rst = 1'b1;
  pwm_duty_decoder_if bus();

  pwm_duty_decoder #(.TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  function automatic logic [W-1:0] mk(bit st, int duty, longint h, longint p);
    logic [2:0] d;
    logic [31:0] hh, pp;
    d = duty[2:0];
    hh = h[31:0];
    pp = p[31:0];
    return {st, d, hh, pp};
  endfunction

  function automatic int classify(longint h, longint p);
    real r;
    r = real'(h) / real'(p);
    if (r < 0.125) return 0;
    if (r < 0.375) return 1;
    if (r < 0.625) return 2;
    if (r < 0.875) return 3;
    return 4;
  endfunction

  // reference model: works on timestamps of rises/falls of the level the
  // decoder sees two samples late; a report is pushed for the following cycle
  bit live = 0;
  bit mdl_clear = 0;
  bit measuring = 0;
  bit h0 = 0, h1 = 0, h2 = 0;
  longint cyc = 0, t0 = 0, tf = 0;

  always @(posedge clk) begin : model
    bit s, sd, rise, fall;
    mdl_clear = rst;
    if (rst) begin
      live = 1;
      h0 = 0; h1 = 0; h2 = 0;
      measuring = 0;
      exp_q.delete();
    end else begin
      s = h1;
      sd = h2;
      rise = s && !sd;
      fall = !s && sd;
      h2 = h1; h1 = h0; h0 = bus.pwm_in;
      cyc++;
      if (!measuring) begin
        if (rise) begin measuring = 1; t0 = cyc; end
      end else if (rise) begin
        exp_q.push_back(mk(1'b0, classify(tf - t0, cyc - t0), tf - t0, cyc - t0));
        t0 = cyc;
      end else if (fall) begin
        tf = cyc;
      end else if (cyc - t0 >= TIMEOUT) begin
        exp_q.push_back(mk(1'b1, s ? 4 : 0, 0, 0));
        measuring = 0;
      end
    end
  end

  // scoreboard: every cycle, valid and the held outputs must match the model
  logic [W-1:0] held = '0;
  always @(negedge clk) begin : compare
    logic [W-1:0] got_w;
    logic exp_v;
    if (live) begin
      exp_v = 1'b0;
      if (mdl_clear) held = '0;
      else if (exp_q.size() != 0) begin
        held = exp_q.pop_front();
        exp_v = 1'b1;
      end
      got_w = {bus.steady, bus.duty_code, bus.high_count, bus.period_count};
      checks++;
      if (bus.valid !== exp_v || got_w !== held) begin
        errors++;
        $display("FAIL outputs t=%0t got valid=%b word=%h required valid=%b word=%h",
                 $time, bus.valid, got_w, exp_v, held);
      end
      if (bus.valid === 1'b1) got_q.push_back(got_w);
    end
  end

  // driver tasks
  task automatic drive(int p, int h, int n);
    for (int i = 0; i < n; i++) begin
      bus.pwm_in = 1'b1;
      repeat (h) @(negedge clk);
      bus.pwm_in = 1'b0;
      repeat (p - h) @(negedge clk);
    end
  endtask

  task automatic hold(bit lvl, int n);
    bus.pwm_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    bus.pwm_in = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold(1'b0, 4);
  endtask

  task automatic chk(string name, logic [W-1:0] got, logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic chk_int(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] dut_word();
    return {bus.steady, bus.duty_code, bus.high_count, bus.period_count};
  endfunction

  initial begin
    int base, r, p, h;
    bus.pwm_in = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_word", dut_word(), '0);
    chk_int("reset_valid", int'(bus.valid), 0);

    // constant low: never a report
    base = got_q.size();
    hold(1'b0, 200);
    chk_int("steady_low_reports", got_q.size() - base, 0);
    chk_int("steady_low_duty", int'(bus.duty_code), 0);

    // P=8, H=2
    do_reset();
    base = got_q.size();
    drive(8, 2, 5);
    hold(1'b0, 4);
    chk_int("p8h2_count", got_q.size() - base, 4);
    chk("p8h2_first", got_q[base], mk(1'b0, 1, 2, 8));
    chk("p8h2_last", got_q[base + 3], mk(1'b0, 1, 2, 8));

    // P=4, H=2 then H=3
    do_reset();
    base = got_q.size();
    drive(4, 2, 4);
    drive(4, 3, 4);
    hold(1'b0, 4);
    chk_int("p4_count", got_q.size() - base, 7);
    chk("p4h2", got_q[base + 2], mk(1'b0, 2, 2, 4));
    chk("p4h3", got_q[base + 6], mk(1'b0, 3, 3, 4));

    // class boundaries
    do_reset();
    base = got_q.size();
    drive(16, 1, 3);
    hold(1'b0, 4);
    chk_int("p16h1_count", got_q.size() - base, 2);
    chk("p16h1", got_q[base + 1], mk(1'b0, 0, 1, 16));

    do_reset();
    base = got_q.size();
    drive(16, 15, 3);
    hold(1'b0, 4);
    chk("p16h15", got_q[base + 1], mk(1'b0, 4, 15, 16));

    do_reset();
    base = got_q.size();
    drive(8, 3, 3);
    hold(1'b0, 4);
    chk("p8h3_edge", got_q[base + 1], mk(1'b0, 2, 3, 8));

    // one rise then constant high: exactly one steady report
    do_reset();
    base = got_q.size();
    hold(1'b1, 100);
    chk_int("hold_high_count", got_q.size() - base, 1);
    chk("hold_high_report", got_q[base], mk(1'b1, 4, 0, 0));
    hold(1'b1, 50);
    chk_int("hold_high_no_repeat", got_q.size() - base, 1);

    // reset in the middle of a high phase
    do_reset();
    drive(8, 4, 2);
    bus.pwm_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_reset_word", dut_word(), '0);
    chk_int("mid_reset_valid", int'(bus.valid), 0);
    base = got_q.size();
    @(negedge clk);
    bus.pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    drive(8, 4, 3);
    hold(1'b0, 4);
    chk_int("after_reset_count", got_q.size() - base, 2);
    chk("after_reset_first", got_q[base], mk(1'b0, 2, 4, 8));

    // randomized waveforms, checked cycle by cycle against the model
    do_reset();
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) hold(1'b1, 70);
      else if (r == 1) hold(1'b0, 70);
      else begin
        p = $urandom_range(2, 40);
        h = $urandom_range(1, p - 1);
        drive(p, h, $urandom_range(1, 4));
      end
    end
    hold(1'b0, 80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
